// File: rtl/gouram_trace_pkg.sv
// gouram_trace_pkg: types shared by the Gouram trace pipeline stages.
//   trace_format - one trace element as it travels IF -> ID -> EX -> WB
//   stage_timing_t / ex_timing_t - per-stage timing records
//   ex_state_e - EX tracker FSM states (also exported as a debug output)
//   max_cnt() - unsigned max of two timestamps
package gouram_trace_pkg;

  localparam int CNT_W      = 32;
  localparam int MEM_ADDR_W = 32;

  typedef struct packed {
    logic [CNT_W-1:0] time_start;
    logic [CNT_W-1:0] time_end;
  } stage_timing_t;

  typedef struct packed {
    logic [CNT_W-1:0]      time_start;
    logic [CNT_W-1:0]      time_end;
    logic                  mem_access;
    logic [MEM_ADDR_W-1:0] mem_addr;
  } ex_timing_t;

  typedef struct packed {
    logic [31:0]   addr;
    logic [31:0]   instruction;
    logic          pass_through;
    stage_timing_t if_data;
    stage_timing_t id_data;
    ex_timing_t    ex_data;
    stage_timing_t wb_data;
  } trace_format;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    CLASSIFY = 3'd2,
    MATCH    = 3'd3,
    OUTPUT   = 3'd4
  } ex_state_e;

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of arbitrary packed element type.
//   clk, rst (async, active-low)
//   push/din  - write din when push; dropped when full unless a pop frees a slot
//               in the same cycle
//   pop       - advance the head; ignored when empty
//   full/empty- occupancy flags
//   head      - current oldest element (valid while !empty); a push becomes
//               visible here one cycle after it is accepted
module trace_fifo #(
  parameter int  DEPTH = 32,
  parameter type T     = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ex_tracker.sv
// ex_tracker: execute-stage tracker of the Gouram trace pipeline.
// Buffers ID trace elements, matches each with the next non-stale EX
// completion event and fills in EX timing (and optionally the data address).
//   clk, rst (async, active-low), counter (cycle count)
//   id_data_valid/id_data_i   - element strobe from the ID tracker
//   ex_valid                  - instruction leaves EX this cycle
//   data_mem_req/data_mem_addr- EX data-memory request (memory capture only)
//   ex_data_o/ex_data_ready   - completed element, one-cycle strobe
//   overflow                  - sticky, set when any FIFO push is dropped
//   state_dbg                 - current FSM state
// Optional feature macro: GOURAM_EX_MEM_TRACE_EN enables capture of the first
// data-memory request per instruction into ex_data.mem_access/mem_addr.
// Handshake: ex_data_ready is a single-cycle strobe with ex_data_o valid in
// the same cycle; there is no back-pressure, the consumer must take it.
module ex_tracker
  import gouram_trace_pkg::*;
#(
  parameter int TRACE_BUFFER_SIZE = 32,
  parameter int EVENT_DEPTH       = 16,
  parameter int DATA_ADDR_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           counter,
  input  logic                       id_data_valid,
  input  trace_format                id_data_i,
  input  logic                       ex_valid,
  input  logic                       data_mem_req,
  input  logic [DATA_ADDR_WIDTH-1:0] data_mem_addr,
  output trace_format                ex_data_o,
  output logic                       ex_data_ready,
  output logic                       overflow,
  output ex_state_e                  state_dbg
);

`ifdef GOURAM_EX_MEM_TRACE_EN
  typedef struct packed {
    logic [CNT_W-1:0]      ts;
    logic                  mem_seen;
    logic [MEM_ADDR_W-1:0] mem_addr;
  } ev_t;
`else
  typedef struct packed {
    logic [CNT_W-1:0] ts;
  } ev_t;
`endif

  ex_state_e        state;
  trace_format      work;
  trace_format      tr_head;
  logic             tr_full, tr_empty, tr_pop_q;
  ev_t              ev_in, ev_head;
  logic             ev_full, ev_empty, ev_pop;
  logic [CNT_W-1:0] start_q, last_ex_end;
  trace_format      pass_elem, matched;

  assign state_dbg = state;

  trace_fifo #(.DEPTH(TRACE_BUFFER_SIZE), .T(trace_format)) u_trace_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (id_data_valid),
    .din   (id_data_i),
    .pop   (tr_pop_q),
    .full  (tr_full),
    .empty (tr_empty),
    .head  (tr_head)
  );

  // MATCH consumes one event per cycle, stale or not.
  assign ev_pop = (state == MATCH) && !ev_empty;

  trace_fifo #(.DEPTH(EVENT_DEPTH), .T(ev_t)) u_event_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ex_valid),
    .din   (ev_in),
    .pop   (ev_pop),
    .full  (ev_full),
    .empty (ev_empty),
    .head  (ev_head)
  );

`ifdef GOURAM_EX_MEM_TRACE_EN
  // First request since the previous ex_valid wins; a request in the same
  // cycle as ex_valid belongs to the instruction leaving EX. Addresses wider
  // than MEM_ADDR_W are truncated.
  logic                  mem_seen_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;

  always_comb begin
    ev_in          = '0;
    ev_in.ts       = counter;
    ev_in.mem_seen = mem_seen_q | data_mem_req;
    if (mem_seen_q)        ev_in.mem_addr = mem_addr_q;
    else if (data_mem_req) ev_in.mem_addr = MEM_ADDR_W'(data_mem_addr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_seen_q <= 1'b0;
      mem_addr_q <= '0;
    end else if (ex_valid) begin
      mem_seen_q <= 1'b0;
      mem_addr_q <= '0;
    end else if (data_mem_req && !mem_seen_q) begin
      mem_seen_q <= 1'b1;
      mem_addr_q <= MEM_ADDR_W'(data_mem_addr);
    end
  end
`else
  logic unused_mem;
  assign unused_mem = ^{data_mem_req, data_mem_addr};

  always_comb begin
    ev_in    = '0;
    ev_in.ts = counter;
  end
`endif

  always_comb begin
    pass_elem         = work;
    pass_elem.ex_data = '0;
    pass_elem.wb_data = '0;

    matched                    = work;
    matched.ex_data            = '0;
    matched.ex_data.time_start = start_q;
    matched.ex_data.time_end   = ev_head.ts;
`ifdef GOURAM_EX_MEM_TRACE_EN
    matched.ex_data.mem_access = ev_head.mem_seen;
    matched.ex_data.mem_addr   = ev_head.mem_addr;
`endif
  end

  // Trace-FIFO pop is registered: issued on leaving IDLE, it takes effect at
  // the end of FETCH, so FETCH still sees the element being popped.
  // The output register and strobe are loaded on the transition into OUTPUT,
  // so ex_data_ready is high while the FSM sits in OUTPUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      tr_pop_q      <= 1'b0;
      work          <= '0;
      start_q       <= '0;
      last_ex_end   <= '0;
      ex_data_o     <= '0;
      ex_data_ready <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      tr_pop_q      <= 1'b0;
      ex_data_ready <= 1'b0;

      if ((id_data_valid && tr_full && !tr_pop_q) || (ex_valid && ev_full && !ev_pop))
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (!tr_empty) begin
            tr_pop_q <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          work  <= tr_head;
          state <= CLASSIFY;
        end
        CLASSIFY: begin
          if (work.pass_through) begin
            ex_data_o     <= pass_elem;
            ex_data_ready <= 1'b1;
            state         <= OUTPUT;
          end else begin
            // EX cannot finish before ID did, nor before the previous EX finish.
            start_q <= max_cnt(work.id_data.time_end + CNT_W'(1), last_ex_end + CNT_W'(1));
            state   <= MATCH;
          end
        end
        MATCH: begin
          if (!ev_empty && (ev_head.ts >= start_q)) begin
            ex_data_o     <= matched;
            ex_data_ready <= 1'b1;
            last_ex_end   <= ev_head.ts;
            state         <= OUTPUT;
          end
        end
        OUTPUT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
